// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the FSM state encoding and framing constants.
package inst_mem_loader_pkg;

    localparam int LDR_ST_WIDTH       = 3;
    localparam int LDR_BYTES_PER_WORD = 4;

    typedef enum logic [LDR_ST_WIDTH-1:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer used for LEN and DATA fields.
// word_o/word_valid are valid in the cycle the 4th byte is presented.
module inst_mem_loader_byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_o,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(LDR_BYTES_PER_WORD - 1);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] acc_q, acc_d;

    assign word_o     = {byte_in, acc_q};
    assign word_valid = byte_en & (idx_q == LAST_IDX);

    // Place each incoming byte at its lane and advance the byte index.
    always_comb begin
        idx_d = idx_q;
        acc_d = acc_q;
        if (clr) begin
            idx_d = 2'd0;
            acc_d = 24'd0;
        end else if (byte_en) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    acc_d[7:0]   = byte_in;
                2'd1:    acc_d[15:8]  = byte_in;
                2'd2:    acc_d[23:16] = byte_in;
                default: acc_d        = acc_q;
            endcase
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            acc_q <= 24'd0;
        end else begin
            idx_q <= idx_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: receives a framed byte stream, writes instruction memory,
// and releases the core reset once the image checksum verifies.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int CPU_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_start,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
    output logic [CPU_WIDTH-1:0]      mem_wdata,
    output logic                      cpu_rst_n,
    output logic                      load_done,
    output logic                      load_err
);

    localparam logic [31:0] DEPTH = 32'd1 << MEM_ADDR_WIDTH;

    ldr_state_e                state_q, state_d;
    logic [31:0]               len_q, len_d;
    logic [MEM_ADDR_WIDTH:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]                xor_q, xor_d;
    logic                      in_ready_q, in_ready_d;
    logic                      mem_wen_q, mem_wen_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_waddr_q, mem_waddr_d;
    logic [CPU_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                      cpu_rst_n_q, cpu_rst_n_d;
    logic                      load_done_q, load_done_d;
    logic                      load_err_q, load_err_d;

    logic        xfer;
    logic        pk_en;
    logic [31:0] pk_word;
    logic        pk_last;

    // A byte offered alongside load_start belongs to no frame.
    assign xfer    = in_valid & in_ready_q & ~load_start;
    assign pk_en   = xfer & ((state_q == ST_LEN) | (state_q == ST_DATA));
    assign cnt_inc = cnt_q + 1'b1;

    inst_mem_loader_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (load_start),
        .byte_en    (pk_en),
        .byte_in    (in_data),
        .word_o     (pk_word),
        .word_valid (pk_last)
    );

    // Frame FSM: length, data words, checksum, then terminal status.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        xor_d       = xor_q;
        mem_wen_d   = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rst_n_d = cpu_rst_n_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        unique case (state_q)
            ST_LEN: begin
                if (xfer) xor_d = xor_q ^ in_data;
                if (pk_last) begin
                    len_d = pk_word;
                    if (pk_word > DEPTH) begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end else if (pk_word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) xor_d = xor_q ^ in_data;
                if (pk_last) begin
                    mem_wen_d   = 1'b1;
                    mem_waddr_d = cnt_q[MEM_ADDR_WIDTH-1:0];
                    mem_wdata_d = CPU_WIDTH'(pk_word);
                    cnt_d       = cnt_inc;
                    if ({{(31-MEM_ADDR_WIDTH){1'b0}}, cnt_inc} == len_q)
                        state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (in_data == xor_q) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                        cpu_rst_n_d = 1'b1;
                    end else begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
        if (load_start) begin
            state_d     = ST_LEN;
            len_d       = 32'd0;
            cnt_d       = '0;
            xor_d       = 8'd0;
            mem_wen_d   = 1'b0;
            cpu_rst_n_d = 1'b0;
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
        end
        in_ready_d = ~load_start &
                     ((state_d == ST_LEN) |
                      (state_d == ST_DATA) |
                      (state_d == ST_CSUM));
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LEN;
            len_q       <= 32'd0;
            cnt_q       <= '0;
            xor_q       <= 8'd0;
            in_ready_q  <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_rst_n_q <= 1'b0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            xor_q       <= xor_d;
            in_ready_q  <= in_ready_d;
            mem_wen_q   <= mem_wen_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_wen   = mem_wen_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: frames are built from a word list,
// expected writes and final status come from the frame rules.
module tb_inst_mem_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    logic [31:0]   wq[$];

    inst_mem_loader #(.CPU_WIDTH(32), .MEM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_wen    (mem_wen),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_rst_n  (cpu_rst_n),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (chk_en) begin
            if (mem_wen) begin
                if (exp_addr.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             mem_waddr, mem_wdata);
                end else begin
                    check("waddr", {24'd0, mem_waddr}, {24'd0, exp_addr.pop_front()});
                    check("wdata", mem_wdata, exp_data.pop_front());
                end
            end
            check("cpu_rst_n_vs_done", {31'd0, cpu_rst_n}, {31'd0, load_done});
            if (load_done | load_err)
                check("ready_when_idle", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        budget   = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            budget++;
            if (budget > 50) begin
                vectors++;
                errors++;
                $display("FAIL byte_timeout: got in_ready 0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] n, input bit flip,
                              input bit gaps, output logic [7:0] csum);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'd0;
        for (int i = 0; i < 4; i++) begin
            x ^= n[8*i +: 8];
            send_byte(n[8*i +: 8], gaps);
        end
        csum = x;
        if (n > DEPTH) return;
        for (int k = 0; k < int'(n); k++) begin
            w = wq[k];
            exp_addr.push_back(k[AW-1:0]);
            exp_data.push_back(w);
            for (int i = 0; i < 4; i++) begin
                x ^= w[8*i +: 8];
                send_byte(w[8*i +: 8], gaps);
            end
        end
        csum = x;
        send_byte(x ^ {7'd0, flip}, gaps);
    endtask

    task automatic restart(input bit with_byte);
        load_start = 1'b1;
        in_valid   = with_byte;
        in_data    = 8'hAA;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        check("ready_after_start", {31'd0, in_ready}, 32'd0);
        check("done_after_start", {31'd0, load_done}, 32'd0);
        check("err_after_start", {31'd0, load_err}, 32'd0);
        check("cpu_rst_after_start", {31'd0, cpu_rst_n}, 32'd0);
    endtask

    task automatic finish_check(input string tag, input bit done);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, load_done}, {31'd0, done});
        check({tag, "_err"}, {31'd0, load_err}, {31'd0, ~done});
        check({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, done});
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_pending_writes"}, exp_addr.size(), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        logic [31:0] n8;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        check("rst_mem_waddr", {24'd0, mem_waddr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);
        chk_en = 1'b1;

        wq = '{32'h00500093, 32'h00100113};
        send_frame(32'd2, 1'b0, 1'b0, cs);
        check("model_csum_t1", {24'd0, cs}, 32'h000000C3);
        finish_check("t1", 1'b1);

        restart(1'b0);
        send_frame(32'd2, 1'b1, 1'b0, cs);
        finish_check("t2", 1'b0);

        restart(1'b0);
        send_frame(32'd257, 1'b0, 1'b0, cs);
        check("t3_err_now", {31'd0, load_err}, 32'd1);
        check("t3_ready_now", {31'd0, in_ready}, 32'd0);
        finish_check("t3", 1'b0);

        restart(1'b0);
        wq.delete();
        send_frame(32'd0, 1'b0, 1'b0, cs);
        check("model_csum_t4", {24'd0, cs}, 32'd0);
        finish_check("t4", 1'b1);

        restart(1'b0);
        wq.delete();
        for (int k = 0; k < 16; k++) wq.push_back($urandom);
        send_frame(32'd16, 1'b0, 1'b1, cs);
        finish_check("t5", 1'b1);

        restart(1'b0);
        wq.delete();
        for (int k = 0; k < 8; k++) wq.push_back($urandom);
        n8 = 32'd8;
        for (int i = 0; i < 4; i++) send_byte(n8[8*i +: 8], 1'b0);
        for (int k = 0; k < 3; k++) begin
            w = wq[k];
            exp_addr.push_back(k[AW-1:0]);
            exp_data.push_back(w);
            for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
        end
        w = wq[3];
        send_byte(w[7:0], 1'b0);
        send_byte(w[15:8], 1'b0);
        restart(1'b1);
        check("t6_abort_writes_done", exp_addr.size(), 32'd0);
        wq.delete();
        wq.push_back($urandom);
        send_frame(32'd1, 1'b0, 1'b0, cs);
        finish_check("t6", 1'b1);

        restart(1'b0);
        wq.delete();
        for (int k = 0; k < DEPTH; k++) wq.push_back($urandom);
        send_frame(32'd256, 1'b0, 1'b0, cs);
        finish_check("t7_full_depth", 1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
